hazard_scoreboard: RTL and testbench

//  Parametrised pipeline interlock for the MIPS core. Tracks, per architectural register, the cycles

---
 rtl/hazard_pkg.sv | 60 ++++++
 rtl/hazard_scoreboard_sb_entry.sv | 40 ++++
 rtl/hazard_scoreboard.sv | 87 ++++++++
 tb/tb_hazard_scoreboard.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the ID-stage interlock: counter sizing, producer latencies and MIPS opcodes.
// Decode uses the helpers below to turn opcode/funct into the id_lat / id_is_branch fields.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int LAT_W      = 3;
  localparam int MAX_LAT    = 4;
  localparam int CNT_W      = 16;

  localparam logic [LAT_W-1:0] LAT_NONE = 3'd0;
  localparam logic [LAT_W-1:0] LAT_ALU  = 3'd1;
  localparam logic [LAT_W-1:0] LAT_LW   = 3'd2;
  localparam logic [LAT_W-1:0] LAT_MULT = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;

  typedef enum logic [1:0] {
    PROD_NONE,
    PROD_ALU,
    PROD_LOAD,
    PROD_MULT
  } prod_e;

  // Stores and branches write no register, so they never create an entry.
  function automatic prod_e classify(input logic [5:0] opcode, input logic [5:0] funct);
    prod_e p;
    p = PROD_NONE;
    case (opcode)
      OP_RTYPE: p = (funct == FN_MULT || funct == FN_MULTU) ? PROD_MULT : PROD_ALU;
      OP_LW:    p = PROD_LOAD;
      OP_SW, OP_BEQ, OP_BNE: p = PROD_NONE;
      default:  p = PROD_ALU;
    endcase
    return p;
  endfunction

  function automatic logic [LAT_W-1:0] prod_lat(input prod_e p);
    logic [LAT_W-1:0] lat;
    lat = LAT_NONE;
    case (p)
      PROD_ALU:  lat = LAT_ALU;
      PROD_LOAD: lat = LAT_LW;
      PROD_MULT: lat = LAT_MULT;
      default:   lat = LAT_NONE;
    endcase
    return lat;
  endfunction

  function automatic logic is_id_branch(input logic [5:0] opcode);
    return (opcode == OP_BEQ) || (opcode == OP_BNE);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One architectural register's countdown: cycles left until its in-flight result can be forwarded.
// A new write never shortens an older, slower write that is still outstanding.
module sb_entry #(
  parameter int LAT_W   = hazard_pkg::LAT_W,
  parameter int MAX_LAT = hazard_pkg::MAX_LAT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set,
  input  logic [LAT_W-1:0] set_lat,
  output logic [LAT_W-1:0] cnt,
  output logic             busy
);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;
  logic [LAT_W-1:0] dec;
  logic [LAT_W-1:0] clamped;

  always_comb begin
    dec     = (cnt_q == '0) ? '0 : cnt_q - LAT_W'(1);
    clamped = (set_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : set_lat;
    cnt_d   = dec;
    if (set && (clamped > dec)) begin
      cnt_d = clamped;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage latency scoreboard: stalls decode while a source operand is not yet forwardable,
// records the destination of each issued producer, and counts stall cycles.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W,
  parameter int MAX_LAT    = hazard_pkg::MAX_LAT,
  parameter int LAT_W      = hazard_pkg::LAT_W,
  parameter int CNT_W      = hazard_pkg::CNT_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_ADDR_W-1:0]    id_rs,
  input  logic [REG_ADDR_W-1:0]    id_rt,
  input  logic                     id_use_rs,
  input  logic                     id_use_rt,
  input  logic                     id_is_branch,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [LAT_W-1:0]         id_lat,
  input  logic                     flush,
  output logic                     stall,
  output logic [2**REG_ADDR_W-1:0] pending,
  output logic [CNT_W-1:0]         stall_cycles
);

  localparam int NUM_REGS = 2**REG_ADDR_W;

  logic [LAT_W-1:0]    cnt_w [NUM_REGS];
  logic [NUM_REGS-1:0] busy_w;

  logic [LAT_W-1:0] thr;
  logic [LAT_W-1:0] rs_cnt;
  logic [LAT_W-1:0] rt_cnt;
  logic             rs_haz;
  logic             rt_haz;
  logic             issue;

  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] stall_cycles_d;

  // r0 is hardwired zero and can never be the source of a hazard.
  assign cnt_w[0]  = '0;
  assign busy_w[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    sb_entry #(
      .LAT_W   (LAT_W),
      .MAX_LAT (MAX_LAT)
    ) u_entry (
      .clock   (clock),
      .reset   (reset),
      .set     (issue && (id_rd == REG_ADDR_W'(r))),
      .set_lat (id_lat),
      .cnt     (cnt_w[r]),
      .busy    (busy_w[r])
    );
  end

  // EX consumers pick up a value that is one cycle from ready via forwarding; ID branches cannot.
  always_comb begin
    thr    = id_is_branch ? '0 : LAT_W'(1);
    rs_cnt = cnt_w[id_rs];
    rt_cnt = cnt_w[id_rt];
    rs_haz = id_use_rs && (rs_cnt > thr);
    rt_haz = id_use_rt && (rt_cnt > thr);
    stall  = id_valid && !flush && (rs_haz || rt_haz);
    issue  = id_valid && !stall && !flush && (id_rd != '0) && (id_lat != '0);
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign pending      = busy_w;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected values are queued as each step is driven
// and popped when the corresponding DUT output is sampled.
module tb_hazard_scoreboard;

  localparam int REG_ADDR_W = 5;
  localparam int LAT_W      = 3;
  localparam int CNT_W      = 16;
  localparam int NUM_REGS   = 2**REG_ADDR_W;

  logic                  clock;
  logic                  reset;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic                  id_is_branch;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [LAT_W-1:0]      id_lat;
  logic                  flush;
  logic                  stall;
  logic [NUM_REGS-1:0]   pending;
  logic [CNT_W-1:0]      stall_cycles;

  logic [31:0] exp_q[$];
  int n_checks;
  int n_errors;

  hazard_scoreboard dut (
    .clock        (clock),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_is_branch (id_is_branch),
    .id_rd        (id_rd),
    .id_lat       (id_lat),
    .flush        (flush),
    .stall        (stall),
    .pending      (pending),
    .stall_cycles (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic br,
                       input logic [4:0] rd, input logic [2:0] lat, input logic fl);
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_use_rs    = urs;
    id_use_rt    = urt;
    id_is_branch = br;
    id_rd        = rd;
    id_lat       = lat;
    flush        = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: observed=%0d but nothing expected was queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        n_errors++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    idle();
    expect_val(32'h0); check("reset_pending", pending);
    expect_val(32'h0); check("reset_stats", 32'(stall_cycles));

    // Reset in the middle of an outstanding write to r5.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 3'd3, 1'b0);
    tick();
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 3'd0, 1'b0);
    expect_val(32'h1); check("r5_branch_stall", 32'(stall));
    tick();
    reset = 1'b1;
    idle();
    expect_val(32'h0000_0020); check("r5_pending_pre_reset", pending);
    expect_val(32'h1); check("stats_pre_reset", 32'(stall_cycles));
    tick();
    tick();
    reset = 1'b0;
    drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 3'd0, 1'b0);
    expect_val(32'h0); check("post_reset_pending", pending);
    expect_val(32'h0); check("post_reset_stall", 32'(stall));
    expect_val(32'h0); check("post_reset_stats", 32'(stall_cycles));
    tick();

    // LW r8 then ADD r9,r8,r1: one stall cycle.
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, hazard_pkg::LAT_LW, 1'b0);
    expect_val(32'h0); check("lw_no_stall", 32'(stall));
    tick();
    drive(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 1'b0, 5'd9, hazard_pkg::LAT_ALU, 1'b0);
    expect_val(32'h1); check("add_stall_c1", 32'(stall));
    tick();
    expect_val(32'h0); check("add_stall_c2", 32'(stall));
    expect_val(32'h1); check("add_stats", 32'(stall_cycles));
    tick();
    idle();
    expect_val(32'h0000_0200); check("add_issued_pending", pending);
    tick();

    // LW r8 then BEQ r8,r0: two stall cycles.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, hazard_pkg::LAT_LW, 1'b0);
    tick();
    drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 3'd0, 1'b0);
    expect_val(32'h1); check("beq_lw_stall_c1", 32'(stall));
    tick();
    expect_val(32'h1); check("beq_lw_stall_c2", 32'(stall));
    tick();
    expect_val(32'h0); check("beq_lw_release", 32'(stall));
    expect_val(32'h3); check("beq_lw_stats", 32'(stall_cycles));
    tick();

    // ALU r10 then BEQ on r10: one stall cycle.
    drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd10, hazard_pkg::LAT_ALU, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd10, 1'b1, 1'b1, 1'b1, 5'd0, 3'd0, 1'b0);
    expect_val(32'h1); check("beq_alu_stall", 32'(stall));
    tick();
    expect_val(32'h0); check("beq_alu_release", 32'(stall));
    expect_val(32'h4); check("beq_alu_stats", 32'(stall_cycles));
    tick();

    // MULT r4, younger ALU r4, then an EX reader of r4 (WAW must not shorten the wait).
    drive(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd4, hazard_pkg::LAT_MULT, 1'b0);
    tick();
    expect_val(32'h4); check("mult_cnt4", 32'(dut.cnt_w[4]));
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 5'd4, hazard_pkg::LAT_ALU, 1'b0);
    expect_val(32'h0); check("waw_alu_no_stall", 32'(stall));
    tick();
    expect_val(32'h3); check("waw_cnt3", 32'(dut.cnt_w[4]));
    drive(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd11, hazard_pkg::LAT_ALU, 1'b0);
    expect_val(32'h1); check("waw_reader_stall_c1", 32'(stall));
    tick();
    expect_val(32'h2); check("waw_cnt2", 32'(dut.cnt_w[4]));
    expect_val(32'h1); check("waw_reader_stall_c2", 32'(stall));
    tick();
    expect_val(32'h1); check("waw_cnt1", 32'(dut.cnt_w[4]));
    expect_val(32'h0); check("waw_reader_release", 32'(stall));
    tick();
    expect_val(32'h0); check("waw_cnt0", 32'(dut.cnt_w[4]));
    expect_val(32'h6); check("waw_stats", 32'(stall_cycles));

    // r0 is never busy; oversized latency is clamped.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, hazard_pkg::LAT_MULT, 1'b0);
    tick();
    expect_val(32'h0); check("r0_pending", pending);
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd12, 3'd7, 1'b0);
    expect_val(32'h0); check("r0_branch_no_stall", 32'(stall));
    tick();
    expect_val(32'h4); check("clamp_cnt", 32'(dut.cnt_w[12]));
    expect_val(32'h0000_1000); check("clamp_pending", pending);

    // Flush beats stall and suppresses issue.
    drive(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 5'd13, hazard_pkg::LAT_LW, 1'b1);
    expect_val(32'h0); check("flush_no_stall", 32'(stall));
    tick();
    expect_val(32'h0000_1000); check("flush_no_issue", pending);
    expect_val(32'h6); check("flush_stats", 32'(stall_cycles));
    idle();
    for (int i = 0; i < 4; i++) tick();

    // Self-dependent branch on r14: issues, then stalls 4 of every 5 cycles until saturation.
    drive(1'b1, 5'd14, 5'd0, 1'b1, 1'b0, 1'b1, 5'd14, hazard_pkg::LAT_MULT, 1'b0);
    expect_val(32'h0); check("self_dep_no_stall", 32'(stall));
    for (int i = 0; i < 5; i++) tick();
    expect_val(32'd10); check("stats_mid", 32'(stall_cycles));
    for (int i = 0; i < 83000; i++) tick();
    expect_val(32'd65535); check("stats_saturated", 32'(stall_cycles));
    for (int i = 0; i < 10; i++) tick();
    expect_val(32'd65535); check("stats_no_wrap", 32'(stall_cycles));
    idle();

    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL leftover_expected: %0d entries never compared", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
